// File: rtl/uart_tx_feeder.sv
// FIFO front end for the UART transmitter: buffers producer words and issues one
// up_data strobe per frame. Optional stats (tx_count, drop_flag) under `UART_TX_FEEDER_STAT_EN.
module uart_tx_feeder #(
  parameter int unsigned N            = 8,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned FRAME_CYCLES = 12
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N-1:0]                 in_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  output logic [N-1:0]                 data,
  output logic                         up_data,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
  output logic                         tx_idle
`ifdef UART_TX_FEEDER_STAT_EN
  ,
  output logic [15:0]                  tx_count,
  output logic                         drop_flag
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned CW = $clog2(FRAME_CYCLES);

  typedef enum logic [1:0] {IDLE, SEND, WAIT} state_t;

  state_t         state;
  logic [N-1:0]   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  guard_cnt;
  logic           full;
  logic           empty;
  logic           push;
  logic           pop;

  // Full/empty come from the registered level only, so there is no same-cycle bypass.
  assign full     = (fifo_level == LW'(DEPTH));
  assign empty    = (fifo_level == '0);
  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign pop      = (state == IDLE) && !empty;
  assign tx_idle  = empty && (state == IDLE);

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      fifo_level <= fifo_level + LW'(push) - LW'(pop);
    end
  end

  // Frame sequencer: up_data is registered alongside the entry into SEND.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      data      <= '0;
      up_data   <= 1'b0;
      guard_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          up_data <= 1'b0;
          if (!empty) begin
            data    <= mem[rd_ptr];
            up_data <= 1'b1;
            state   <= SEND;
          end
        end
        SEND: begin
          up_data   <= 1'b0;
          guard_cnt <= CW'(FRAME_CYCLES - 1);
          state     <= WAIT;
        end
        WAIT: begin
          up_data <= 1'b0;
          if (guard_cnt == '0) state <= IDLE;
          else                 guard_cnt <= guard_cnt - CW'(1);
        end
        default: begin
          up_data <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_FEEDER_STAT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_count  <= '0;
      drop_flag <= 1'b0;
    end else begin
      if (state == SEND)     tx_count  <= tx_count + 16'd1;
      if (in_valid && full)  drop_flag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized bench for uart_tx_feeder against a queue-based frame-timing model.
module tb_uart_tx_feeder;

  localparam int N     = 8;
  localparam int DEPTH = 8;
  localparam int FC    = 12;
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int VW    = 1 + N + LW + 2;

  logic          clk;
  logic          rst;
  logic [N-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  data;
  logic          up_data;
  logic [LW-1:0] fifo_level;
  logic          tx_idle;
`ifdef UART_TX_FEEDER_STAT_EN
  logic [15:0]   tx_count;
  logic          drop_flag;
`endif

  uart_tx_feeder #(.N(N), .DEPTH(DEPTH), .FRAME_CYCLES(FC)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .data       (data),
    .up_data    (up_data),
    .fifo_level (fifo_level),
    .tx_idle    (tx_idle)
`ifdef UART_TX_FEEDER_STAT_EN
    ,
    .tx_count   (tx_count),
    .drop_flag  (drop_flag)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;

  // Model: words queue up; a word leaves when the queue is non-empty and the
  // previous frame (pulse + FC guard + one idle cycle) has elapsed.
  logic [N-1:0] q[$];
  int           cyc;
  int           next_pop_ok;
  logic [N-1:0] m_data;
  logic         m_pulse;
  logic [15:0]  m_sends;
  logic         send_pending;
  logic         m_drop;
  bit           do_pop;
  bit           do_push;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      cyc          = 0;
      next_pop_ok  = 0;
      m_data       = '0;
      m_pulse      = 1'b0;
      m_sends      = '0;
      send_pending = 1'b0;
      m_drop       = 1'b0;
    end else begin
      cyc++;
      if (send_pending) m_sends = m_sends + 16'd1;
      send_pending = 1'b0;
      do_push = in_valid && (q.size() < DEPTH);
      if (in_valid && q.size() == DEPTH) m_drop = 1'b1;
      do_pop  = (q.size() > 0) && (cyc >= next_pop_ok);
      m_pulse = 1'b0;
      if (do_pop) begin
        m_data       = q.pop_front();
        m_pulse      = 1'b1;
        send_pending = 1'b1;
        next_pop_ok  = cyc + FC + 2;
      end
      if (do_push) q.push_back(in_data);
    end
  end

  logic [VW-1:0] act_vec;
  assign act_vec = {up_data, data, fifo_level, in_ready, tx_idle};

  function automatic logic [VW-1:0] exp_vec();
    return {m_pulse, m_data, LW'(q.size()), (q.size() < DEPTH),
            (q.size() == 0 && cyc >= next_pop_ok - 1)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vecs++; if (data !== '0)       begin errs++; $display("FAIL reset_data act=%h exp=00", data); end
    vecs++; if (up_data !== 1'b0)  begin errs++; $display("FAIL reset_up_data act=%b exp=0", up_data); end
    vecs++; if (fifo_level !== '0) begin errs++; $display("FAIL reset_level act=%0d exp=0", fifo_level); end
    vecs++; if (in_ready !== 1'b1) begin errs++; $display("FAIL reset_in_ready act=%b exp=1", in_ready); end
    vecs++; if (tx_idle !== 1'b1)  begin errs++; $display("FAIL reset_tx_idle act=%b exp=1", tx_idle); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    in_valid = 1'b1; in_data = 8'b10100101;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); @(negedge clk);
      if (i == 0) in_valid = 1'b0;
      vecs++;
      if (act_vec !== exp_vec()) begin
        errs++; $display("FAIL single_vec i=%0d act=%h exp=%h", i, act_vec, exp_vec());
      end
      vecs++;
      if (up_data !== 1'(i == 1)) begin
        errs++; $display("FAIL single_pulse i=%0d act=%b exp=%b", i, up_data, (i == 1));
      end
      if (i >= 1) begin
        vecs++;
        if (data !== 8'b10100101) begin
          errs++; $display("FAIL single_data i=%0d act=%h exp=a5", i, data);
        end
      end
    end
  endtask

  task automatic test_burst();
    int pulse_at[$];
    logic [7:0] exp_b = 8'h01;
    in_valid = 1'b1; in_data = 8'h01;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); @(negedge clk);
      if (i < 3) in_data = 8'(i + 2);
      else       in_valid = 1'b0;
      vecs++;
      if (act_vec !== exp_vec()) begin
        errs++; $display("FAIL burst_vec i=%0d act=%h exp=%h", i, act_vec, exp_vec());
      end
      if (up_data === 1'b1) begin
        pulse_at.push_back(i);
        vecs++;
        if (data !== exp_b) begin errs++; $display("FAIL burst_data act=%h exp=%h", data, exp_b); end
        exp_b++;
      end
    end
    vecs++;
    if (pulse_at.size() != 4) begin
      errs++; $display("FAIL burst_count act=%0d exp=4", pulse_at.size());
    end
    for (int k = 1; k < pulse_at.size(); k++) begin
      vecs++;
      if (pulse_at[k] - pulse_at[k-1] != FC + 2) begin
        errs++; $display("FAIL burst_spacing k=%0d act=%0d exp=%0d", k, pulse_at[k] - pulse_at[k-1], FC + 2);
      end
    end
    vecs++; if (tx_idle !== 1'b1) begin errs++; $display("FAIL burst_idle act=%b exp=1", tx_idle); end
  endtask

  task automatic test_full_wrap();
    logic [7:0] offered [10];
    int got = 0;
    int w = 0;
    in_valid = 1'b1; in_data = 8'($urandom);
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    while (up_data !== 1'b1 && w < 10) begin
      @(posedge clk); @(negedge clk); w++;
    end
    vecs++; if (w >= 10) begin errs++; $display("FAIL wrap_first_pulse act=timeout exp=pulse"); end
    for (int i = 0; i < 10; i++) begin
      offered[i] = 8'($urandom);
      in_valid = 1'b1; in_data = offered[i];
      @(posedge clk); @(negedge clk);
      vecs++;
      if (act_vec !== exp_vec()) begin
        errs++; $display("FAIL wrap_fill_vec i=%0d act=%h exp=%h", i, act_vec, exp_vec());
      end
    end
    in_valid = 1'b0;
    vecs++; if (in_ready !== 1'b0) begin errs++; $display("FAIL wrap_in_ready act=%b exp=0", in_ready); end
    vecs++; if (fifo_level !== LW'(DEPTH)) begin errs++; $display("FAIL wrap_level act=%0d exp=%0d", fifo_level, DEPTH); end
    for (int i = 0; i < 9 * (FC + 2); i++) begin
      @(posedge clk); @(negedge clk);
      vecs++;
      if (act_vec !== exp_vec()) begin
        errs++; $display("FAIL wrap_drain_vec i=%0d act=%h exp=%h", i, act_vec, exp_vec());
      end
      if (up_data === 1'b1) begin
        if (got < 8) begin
          vecs++;
          if (data !== offered[got]) begin
            errs++; $display("FAIL wrap_order n=%0d act=%h exp=%h", got, data, offered[got]);
          end
        end
        got++;
      end
    end
    vecs++; if (got != 8) begin errs++; $display("FAIL wrap_pulses act=%0d exp=8", got); end
  endtask

  task automatic test_reset_midframe();
    int w = 0;
    int pulses = 0;
    in_valid = 1'b1; in_data = 8'hC5;
    @(posedge clk); @(negedge clk);
    in_data = 8'h2B;
    @(posedge clk); @(negedge clk);
    in_valid = 1'b0;
    while (up_data !== 1'b1 && w < 10) begin
      @(posedge clk); @(negedge clk); w++;
    end
    vecs++; if (w >= 10) begin errs++; $display("FAIL midrst_pulse act=timeout exp=pulse"); end
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    vecs++; if (up_data !== 1'b0)  begin errs++; $display("FAIL midrst_up_data act=%b exp=0", up_data); end
    vecs++; if (fifo_level !== '0) begin errs++; $display("FAIL midrst_level act=%0d exp=0", fifo_level); end
    vecs++; if (tx_idle !== 1'b1)  begin errs++; $display("FAIL midrst_idle act=%b exp=1", tx_idle); end
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); @(negedge clk);
      if (up_data === 1'b1) pulses++;
      vecs++;
      if (act_vec !== exp_vec()) begin
        errs++; $display("FAIL midrst_vec i=%0d act=%h exp=%h", i, act_vec, exp_vec());
      end
    end
    vecs++; if (pulses != 0) begin errs++; $display("FAIL midrst_no_pulse act=%0d exp=0", pulses); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 560; i++) begin
      if (i < 200)      in_valid = ($urandom_range(0, 1) == 0);
      else if (i < 400) in_valid = ($urandom_range(0, 19) == 0);
      else              in_valid = 1'b0;
      in_data = 8'($urandom);
      @(posedge clk); @(negedge clk);
      vecs++;
      if (act_vec !== exp_vec()) begin
        errs++; $display("FAIL random_vec i=%0d act=%h exp=%h", i, act_vec, exp_vec());
      end
`ifdef UART_TX_FEEDER_STAT_EN
      vecs++;
      if ({tx_count, drop_flag} !== {m_sends, m_drop}) begin
        errs++; $display("FAIL random_stat i=%0d act=%h/%b exp=%h/%b", i, tx_count, drop_flag, m_sends, m_drop);
      end
`endif
    end
    in_valid = 1'b0;
  endtask

`ifdef UART_TX_FEEDER_STAT_EN
  task automatic test_stat();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    vecs++; if (tx_count !== 16'd0) begin errs++; $display("FAIL stat_reset_count act=%0d exp=0", tx_count); end
    vecs++; if (drop_flag !== 1'b0) begin errs++; $display("FAIL stat_reset_drop act=%b exp=0", drop_flag); end
    for (int i = 0; i < 85; i++) begin
      in_valid = (i < 5); in_data = 8'($urandom);
      @(posedge clk); @(negedge clk);
    end
    in_valid = 1'b0;
    vecs++; if (tx_count !== 16'd5) begin errs++; $display("FAIL stat_count5 act=%0d exp=5", tx_count); end
    vecs++; if (drop_flag !== 1'b0) begin errs++; $display("FAIL stat_nodrop act=%b exp=0", drop_flag); end
    for (int i = 0; i < 14; i++) begin
      in_valid = 1'b1; in_data = 8'($urandom);
      @(posedge clk); @(negedge clk);
      vecs++;
      if ({tx_count, drop_flag} !== {m_sends, m_drop}) begin
        errs++; $display("FAIL stat_fill i=%0d act=%h/%b exp=%h/%b", i, tx_count, drop_flag, m_sends, m_drop);
      end
    end
    in_valid = 1'b0;
    vecs++; if (drop_flag !== 1'b1) begin errs++; $display("FAIL stat_drop act=%b exp=1", drop_flag); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    vecs++; if (tx_count !== 16'd0) begin errs++; $display("FAIL stat_clr_count act=%0d exp=0", tx_count); end
    vecs++; if (drop_flag !== 1'b0) begin errs++; $display("FAIL stat_clr_drop act=%b exp=0", drop_flag); end
    rst = 1'b0;
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_data = '0;
    test_reset();
    test_single();
    test_burst();
    test_full_wrap();
    test_reset_midframe();
    test_random();
`ifdef UART_TX_FEEDER_STAT_EN
    test_stat();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
